// File: rtl/stat_snapshot_reader.sv
// ---------------------------------------------------------------------------
// stat_snapshot_reader
//
// Per-port AXI-Stream statistics with wide counters (bytes, frames, drops,
// stalls) and a request/response read port that returns 32-bit halves.
// A low-half read captures the full counter and parks its upper half in a
// single global hold register, so a following high-half read returns the
// upper bits of the same counter value.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   port_clear           per-port synchronous zero of all four counters
//   monitor_axis_*       monitored AXI-Stream handshake (tkeep/tvalid/tready/tlast)
//   monitor_drop_pulse   per-port one-cycle drop event
//   rd_req_valid/ready   read request handshake
//   rd_port/stat/high    read address: port, statistic (0..3), half select
//   rd_resp_valid/ready  read response handshake
//   rd_resp_data         32-bit response data
// ---------------------------------------------------------------------------
module stat_snapshot_reader #(
    parameter int PORT_COUNT    = 4,
    parameter int KEEP_WIDTH    = 8,
    parameter int COUNTER_WIDTH = 48,
    parameter bit SATURATE      = 1'b0,
    parameter bit CLEAR_ON_READ = 1'b0,
    parameter int PORT_WIDTH    = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORT_COUNT-1:0]            port_clear,
    input  logic [PORT_COUNT*KEEP_WIDTH-1:0] monitor_axis_tkeep,
    input  logic [PORT_COUNT-1:0]            monitor_axis_tvalid,
    input  logic [PORT_COUNT-1:0]            monitor_axis_tready,
    input  logic [PORT_COUNT-1:0]            monitor_axis_tlast,
    input  logic [PORT_COUNT-1:0]            monitor_drop_pulse,
    input  logic                             rd_req_valid,
    output logic                             rd_req_ready,
    input  logic [PORT_WIDTH-1:0]            rd_port,
    input  logic [1:0]                       rd_stat,
    input  logic                             rd_high,
    output logic                             rd_resp_valid,
    input  logic                             rd_resp_ready,
    output logic [31:0]                      rd_resp_data
);

    typedef logic [COUNTER_WIDTH-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_MUX  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Number of set bits in a tkeep word, widened to counter width.
    function automatic cnt_t popcount(input logic [KEEP_WIDTH-1:0] keep);
        cnt_t n;
        n = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            n = n + cnt_t'(keep[i]);
        end
        return n;
    endfunction

    // Counter add with optional stick-at-all-ones on overflow.
    function automatic cnt_t sat_add(input cnt_t a, input cnt_t b);
        logic [COUNTER_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (SATURATE && sum[COUNTER_WIDTH]) begin
            return '1;
        end else begin
            return sum[COUNTER_WIDTH-1:0];
        end
    endfunction

    // Registered monitor inputs
    logic [PORT_COUNT*KEEP_WIDTH-1:0] tkeep_r;
    logic [PORT_COUNT-1:0]            tvalid_r;
    logic [PORT_COUNT-1:0]            tready_r;
    logic [PORT_COUNT-1:0]            tlast_r;
    logic [PORT_COUNT-1:0]            drop_r;

    // Counters indexed [port][stat], stat 0=bytes 1=frames 2=drops 3=stalls
    logic [PORT_COUNT-1:0][3:0][COUNTER_WIDTH-1:0] cnt_r;
    logic [PORT_COUNT-1:0][3:0][COUNTER_WIDTH-1:0] cnt_next_s;
    logic [PORT_COUNT-1:0][3:0][COUNTER_WIDTH-1:0] inc_s;

    // Read pipeline
    state_t                                state_r;
    logic [PORT_WIDTH-1:0]                 port_r;
    logic [1:0]                            stat_r;
    logic                                  high_r;
    logic [PORT_COUNT-1:0][COUNTER_WIDTH-1:0] sel_val_r;
    logic [PORT_COUNT-1:0]                 sel_clr_r;
    logic [31:0]                           hold_r;

    logic port_ok_s;
    cnt_t mux_val_s;
    logic cor_hit_s;

    assign port_ok_s = (32'(port_r) < PORT_COUNT);
    assign mux_val_s = port_ok_s ? sel_val_r[port_r] : '0;
    assign cor_hit_s = CLEAR_ON_READ && (state_r == ST_MUX) && !high_r && port_ok_s;

    // Capture the monitored handshake one cycle ahead of counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tkeep_r  <= '0;
            tvalid_r <= '0;
            tready_r <= '0;
            tlast_r  <= '0;
            drop_r   <= '0;
        end else begin
            tkeep_r  <= monitor_axis_tkeep;
            tvalid_r <= monitor_axis_tvalid & ~{PORT_COUNT{rst}};
            tready_r <= monitor_axis_tready;
            tlast_r  <= monitor_axis_tlast;
            drop_r   <= monitor_drop_pulse;
        end
    end

    // Per-port, per-stat increment amounts from the registered monitors
    always_comb begin
        inc_s = '0;
        for (int p = 0; p < PORT_COUNT; p++) begin
            if (tvalid_r[p] && tready_r[p]) begin
                inc_s[p][0] = popcount(tkeep_r[p*KEEP_WIDTH +: KEEP_WIDTH]);
            end else begin
                inc_s[p][0] = '0;
            end
            inc_s[p][1] = cnt_t'(tvalid_r[p] & tready_r[p] & tlast_r[p]);
            inc_s[p][2] = cnt_t'(drop_r[p]);
            inc_s[p][3] = cnt_t'(tvalid_r[p] & ~tready_r[p]);
        end
    end

    // Next counter values: clear wins, clear-on-read keeps late events
    always_comb begin
        cnt_next_s = cnt_r;
        for (int p = 0; p < PORT_COUNT; p++) begin
            for (int s = 0; s < 4; s++) begin
                if (port_clear[p]) begin
                    cnt_next_s[p][s] = '0;
                end else if (cor_hit_s && (port_r == PORT_WIDTH'(p)) && (stat_r == 2'(s))) begin
                    // Keep only what arrived after the SEL-stage capture: the
                    // difference is the increment landed on the SEL edge, unless
                    // a port_clear zeroed the counter on that edge.
                    if (sel_clr_r[p]) begin
                        cnt_next_s[p][s] = sat_add(cnt_r[p][s], inc_s[p][s]);
                    end else begin
                        cnt_next_s[p][s] = sat_add(cnt_r[p][s] - sel_val_r[p], inc_s[p][s]);
                    end
                end else begin
                    cnt_next_s[p][s] = sat_add(cnt_r[p][s], inc_s[p][s]);
                end
            end
        end
    end

    // Counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    // Read FSM: IDLE -> SEL (stat mux) -> MUX (port mux, hold) -> RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            port_r        <= '0;
            stat_r        <= 2'd0;
            high_r        <= 1'b0;
            sel_val_r     <= '0;
            sel_clr_r     <= '0;
            hold_r        <= 32'd0;
            rd_req_ready  <= 1'b1;
            rd_resp_valid <= 1'b0;
            rd_resp_data  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rd_req_valid) begin
                        port_r       <= rd_port;
                        stat_r       <= rd_stat;
                        high_r       <= rd_high;
                        rd_req_ready <= 1'b0;
                        state_r      <= ST_SEL;
                    end else begin
                        rd_req_ready <= 1'b1;
                    end
                end
                ST_SEL: begin
                    for (int p = 0; p < PORT_COUNT; p++) begin
                        sel_val_r[p] <= cnt_r[p][stat_r];
                    end
                    sel_clr_r <= port_clear;
                    state_r   <= ST_MUX;
                end
                ST_MUX: begin
                    if (high_r) begin
                        rd_resp_data <= hold_r;
                    end else begin
                        rd_resp_data <= mux_val_s[31:0];
                        hold_r       <= 32'(mux_val_s >> 32);
                    end
                    rd_resp_valid <= 1'b1;
                    state_r       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rd_resp_ready) begin
                        rd_resp_valid <= 1'b0;
                        rd_req_ready  <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else begin
                        rd_resp_valid <= 1'b1;
                    end
                end
                default: begin
                    rd_resp_valid <= 1'b0;
                    rd_req_ready  <= 1'b1;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stat_snapshot_reader.sv
// ---------------------------------------------------------------------------
// tb_stat_snapshot_reader
//
// Directed bench for stat_snapshot_reader. Three instances share all inputs:
//   dut      default parameters (48-bit, wrap, no clear-on-read)
//   dut_sat  33-bit counters with saturation
//   dut_cor  48-bit counters with clear-on-read
// Each scenario checks the instance whose mode it exercises.
// ---------------------------------------------------------------------------
module tb_stat_snapshot_reader;

    logic        clk;
    logic        rst;
    logic [3:0]  port_clear;
    logic [31:0] tkeep;
    logic [3:0]  tvalid;
    logic [3:0]  tready;
    logic [3:0]  tlast;
    logic [3:0]  drop;
    logic        rd_req_valid;
    logic [1:0]  rd_port;
    logic [1:0]  rd_stat;
    logic        rd_high;
    logic        rd_resp_ready;

    logic        rd_req_ready,  rd_req_ready_sat,  rd_req_ready_cor;
    logic        rd_resp_valid, rd_resp_valid_sat, rd_resp_valid_cor;
    logic [31:0] rd_resp_data,  rd_resp_data_sat,  rd_resp_data_cor;

    int n_assert;
    int n_fail;

    logic [3:0][3:0][47:0] snap48;
    logic [3:0][3:0][32:0] snap33;
    logic [31:0] d0, d1, d2;

    stat_snapshot_reader dut (
        .clk(clk), .rst(rst), .port_clear(port_clear),
        .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid),
        .monitor_axis_tready(tready), .monitor_axis_tlast(tlast),
        .monitor_drop_pulse(drop),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_port(rd_port), .rd_stat(rd_stat), .rd_high(rd_high),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
        .rd_resp_data(rd_resp_data)
    );

    stat_snapshot_reader #(.COUNTER_WIDTH(33), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .port_clear(port_clear),
        .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid),
        .monitor_axis_tready(tready), .monitor_axis_tlast(tlast),
        .monitor_drop_pulse(drop),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready_sat),
        .rd_port(rd_port), .rd_stat(rd_stat), .rd_high(rd_high),
        .rd_resp_valid(rd_resp_valid_sat), .rd_resp_ready(rd_resp_ready),
        .rd_resp_data(rd_resp_data_sat)
    );

    stat_snapshot_reader #(.CLEAR_ON_READ(1'b1)) dut_cor (
        .clk(clk), .rst(rst), .port_clear(port_clear),
        .monitor_axis_tkeep(tkeep), .monitor_axis_tvalid(tvalid),
        .monitor_axis_tready(tready), .monitor_axis_tlast(tlast),
        .monitor_drop_pulse(drop),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready_cor),
        .rd_port(rd_port), .rd_stat(rd_stat), .rd_high(rd_high),
        .rd_resp_valid(rd_resp_valid_cor), .rd_resp_ready(rd_resp_ready),
        .rd_resp_data(rd_resp_data_cor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mon_idle();
        tkeep  = 32'd0;
        tvalid = 4'd0;
        tready = 4'd0;
        tlast  = 4'd0;
        drop   = 4'd0;
    endtask

    task automatic set_beat(input int p, input logic [7:0] keep, input logic last);
        tkeep[p*8 +: 8] = keep;
        tvalid[p]       = 1'b1;
        tready[p]       = 1'b1;
        tlast[p]        = last;
    endtask

    // One read on all three instances; drop_port >= 0 pulses that port's drop
    // input so the registered pulse lands on the MUX-cycle edge.
    task automatic do_read(input int port, input int stat, input logic high, input int drop_port,
                           output logic [31:0] r0, output logic [31:0] r1, output logic [31:0] r2);
        int waited;
        chk("req_ready_idle", 64'({rd_req_ready, rd_req_ready_sat, rd_req_ready_cor}), 64'd7);
        rd_req_valid = 1'b1;
        rd_port      = 2'(port);
        rd_stat      = 2'(stat);
        rd_high      = high;
        step(1);
        rd_req_valid = 1'b0;
        if (drop_port >= 0) drop[drop_port] = 1'b1;
        step(1);
        drop = 4'd0;
        waited = 0;
        while (!rd_resp_valid && waited < 8) begin
            step(1);
            waited++;
        end
        chk("resp_valid", 64'({rd_resp_valid, rd_resp_valid_sat, rd_resp_valid_cor}), 64'd7);
        r0 = rd_resp_data;
        r1 = rd_resp_data_sat;
        r2 = rd_resp_data_cor;
        step(1);
    endtask

    initial begin
        int waited;
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        port_clear    = 4'd0;
        rd_req_valid  = 1'b0;
        rd_port       = 2'd0;
        rd_stat       = 2'd0;
        rd_high       = 1'b0;
        rd_resp_ready = 1'b1;
        mon_idle();
        step(3);
        rst = 1'b0;

        // Reset state
        chk("rst_req_ready", 64'(rd_req_ready), 64'd1);
        chk("rst_resp_valid", 64'(rd_resp_valid), 64'd0);
        chk("rst_resp_data", 64'(rd_resp_data), 64'd0);
        step(1);
        do_read(0, 0, 1'b0, -1, d0, d1, d2);
        chk("rst_bytes_p0", 64'(d0), 64'd0);

        // Port 1: 10 full beats, tlast on the 10th
        for (int i = 1; i <= 10; i++) begin
            set_beat(1, 8'hFF, (i == 10) ? 1'b1 : 1'b0);
            step(1);
        end
        mon_idle();
        step(3);
        do_read(1, 0, 1'b0, -1, d0, d1, d2);
        chk("p1_bytes_lo", 64'(d0), 64'd80);
        do_read(1, 0, 1'b1, -1, d0, d1, d2);
        chk("p1_bytes_hi", 64'(d0), 64'd0);
        do_read(1, 1, 1'b0, -1, d0, d1, d2);
        chk("p1_frames_lo", 64'(d0), 64'd1);
        do_read(1, 1, 1'b1, -1, d0, d1, d2);
        chk("p1_frames_hi", 64'(d0), 64'd0);

        // Port 3 bytes preloaded so 8 beats of 5 bytes reach 2^32 + 5
        snap48 = dut.cnt_r;
        snap48[3][0] = 48'hFFFF_FFDD;
        force dut.cnt_r = snap48;
        step(1);
        release dut.cnt_r;
        for (int i = 0; i < 8; i++) begin
            set_beat(3, 8'h1F, 1'b0);
            step(1);
        end
        mon_idle();
        step(3);
        do_read(3, 0, 1'b0, -1, d0, d1, d2);
        chk("p3_bytes_lo_carry", 64'(d0), 64'h0000_0005);
        do_read(3, 0, 1'b1, -1, d0, d1, d2);
        chk("p3_bytes_hi_carry", 64'(d0), 64'h0000_0001);

        // Port 0 stalls: saturate (33-bit) vs wrap (48-bit), both 2 below max
        snap48 = dut.cnt_r;
        snap48[0][3] = 48'hFFFF_FFFF_FFFE;
        snap33 = dut_sat.cnt_r;
        snap33[0][3] = 33'h1_FFFF_FFFE;
        force dut.cnt_r = snap48;
        force dut_sat.cnt_r = snap33;
        step(1);
        release dut.cnt_r;
        release dut_sat.cnt_r;
        tvalid[0] = 1'b1;
        tready[0] = 1'b0;
        step(4);
        mon_idle();
        step(3);
        do_read(0, 3, 1'b0, -1, d0, d1, d2);
        chk("sat_stall_lo", 64'(d1), 64'hFFFF_FFFF);
        chk("wrap_stall_lo", 64'(d0), 64'd2);
        do_read(0, 3, 1'b1, -1, d0, d1, d2);
        chk("sat_stall_hi", 64'(d1), 64'h0000_0001);
        chk("wrap_stall_hi", 64'(d0), 64'd0);
        tvalid[0] = 1'b1;
        tready[0] = 1'b0;
        step(2);
        mon_idle();
        step(3);
        do_read(0, 3, 1'b0, -1, d0, d1, d2);
        chk("sat_stall_lo_hold", 64'(d1), 64'hFFFF_FFFF);
        chk("wrap_stall_lo_more", 64'(d0), 64'd4);
        do_read(0, 3, 1'b1, -1, d0, d1, d2);
        chk("sat_stall_hi_hold", 64'(d1), 64'h0000_0001);

        // Clear-on-read with a drop landing in the MUX cycle
        for (int i = 0; i < 7; i++) begin
            drop[2] = 1'b1;
            step(1);
        end
        drop = 4'd0;
        step(3);
        do_read(2, 2, 1'b0, 2, d0, d1, d2);
        chk("cor_drop_first", 64'(d2), 64'd7);
        chk("nocor_drop_first", 64'(d0), 64'd7);
        do_read(2, 2, 1'b0, -1, d0, d1, d2);
        chk("cor_drop_second", 64'(d2), 64'd1);
        chk("nocor_drop_second", 64'(d0), 64'd8);
        do_read(2, 2, 1'b0, -1, d0, d1, d2);
        chk("cor_drop_third", 64'(d2), 64'd0);

        // port_clear[2] during port-2 traffic; port 0 traffic in parallel
        set_beat(0, 8'h0F, 1'b0);
        set_beat(2, 8'h03, 1'b0);
        step(1);
        set_beat(0, 8'hA5, 1'b0);
        set_beat(2, 8'h03, 1'b1);
        step(1);
        set_beat(0, 8'h01, 1'b1);
        set_beat(2, 8'hFF, 1'b0);
        port_clear = 4'b0100;
        step(1);
        mon_idle();
        step(1);
        port_clear = 4'd0;
        step(3);
        for (int s = 0; s < 4; s++) begin
            do_read(2, s, 1'b0, -1, d0, d1, d2);
            chk($sformatf("p2_cleared_stat%0d", s), 64'(d0), 64'd0);
        end
        do_read(0, 0, 1'b0, -1, d0, d1, d2);
        chk("p0_bytes_kept", 64'(d0), 64'd9);
        do_read(0, 1, 1'b0, -1, d0, d1, d2);
        chk("p0_frames_kept", 64'(d0), 64'd1);
        do_read(0, 3, 1'b0, -1, d0, d1, d2);
        chk("p0_stalls_kept", 64'(d0), 64'd4);

        // Response back-pressure: data and ready stay put while waiting
        rd_resp_ready = 1'b0;
        rd_req_valid  = 1'b1;
        rd_port = 2'd0;
        rd_stat = 2'd0;
        rd_high = 1'b0;
        step(1);
        rd_req_valid = 1'b0;
        waited = 0;
        while (!rd_resp_valid && waited < 8) begin
            step(1);
            waited++;
        end
        chk("bp_valid_seen", 64'(rd_resp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_data_stable", 64'(rd_resp_data), 64'd9);
            chk("bp_valid_stable", 64'(rd_resp_valid), 64'd1);
            chk("bp_req_ready_low", 64'(rd_req_ready), 64'd0);
            step(1);
        end
        rd_resp_ready = 1'b1;
        step(1);
        chk("bp_valid_cleared", 64'(rd_resp_valid), 64'd0);
        chk("bp_req_ready_back", 64'(rd_req_ready), 64'd1);

        // Reset in the SEL cycle aborts the read
        rd_req_valid = 1'b1;
        rd_port = 2'd1;
        rd_stat = 2'd0;
        rd_high = 1'b0;
        step(1);
        rd_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_valid_in_rst", 64'(rd_resp_valid), 64'd0);
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_resp", 64'(rd_resp_valid), 64'd0);
            step(1);
        end
        do_read(1, 0, 1'b0, -1, d0, d1, d2);
        chk("post_rst_p1_bytes", 64'(d0), 64'd0);
        do_read(0, 3, 1'b0, -1, d0, d1, d2);
        chk("post_rst_p0_stalls", 64'(d0), 64'd0);
        do_read(3, 0, 1'b1, -1, d0, d1, d2);
        chk("post_rst_hold", 64'(d0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
